eth_mii_rx_frame_buffer: RTL and testbench
==========================================

Name: eth_mii_rx_frame_buffer

Overview:
MII receive front end for the Ethernet IP. It samples 4-bit MII nibbles, detects preamble/SFD and assembles payload bytes low nibble first. Each byte passes through a small byte FIFO and is stored into a single-frame dual-port RAM buffer. A MAC-side interface announces a buffered frame, streams it out byte by byte, and releases or discards the buffer.

Parameters:
FRAME_SIZE, 1520, max bytes stored per frame; excess bytes are dropped.
ADDR_W, 16, RAM address and byte counter width.
FIFO_DEPTH, 2, byte FIFO entries.

Ports:
eth_mii_rx_clk  in  1  sole clock. One clock; all logic on rising edge.
eth_mii_rst  in  1  reset; asynchronous, active-high.
mii_rx_dv  in  1  MII receive data valid.
mii_rxd  in  4  MII receive nibble.
mac_new_frame_available  out  1  frame started in buffer, not yet being read.
mac_start_read  in  1  pulse: begin reading the frame (issues RAM read of addr 0).
mac_rd_avail  out  1  mac_rd_data holds the next byte.
mac_rd_en  in  1  consume mac_rd_data; honoured only when mac_rd_avail=1.
mac_rd_data  out  8  RAM port-B output byte.
mac_last_data_rcvd  out  1  frame complete and every byte consumed.
mac_finished_read  in  1  pulse: release buffer.
mac_stop_rx  in  1  pulse: abort and discard current frame.
mac_bytes_sent  out  16  bytes consumed so far.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and flags 0.
- Sampler stage: registers mii_rx_dv and mii_rxd each cycle.
- PHY FSM, IDLE -> PAYLOAD: on sampled dv=1, nibble=0xD and previous nibble=0x5.
- PHY FSM, back to IDLE: on any sampled dv=0.
- Nibble pairing: is_msb is cleared in IDLE and toggles each PAYLOAD cycle.
  - When PAYLOAD && is_msb && dv, enqueue {valid=1, {cur_nibble, prev_nibble}}.
  - In IDLE, enqueue {valid=0, x} every cycle.
- Store stage: dequeues the FIFO head every cycle and tracks prev_valid. The RAM write plus counter update occur on the 3rd edge after the high nibble is sampled.
  - Rising valid, buffer free: buffer_in_use=1, storing=1, write addr 0, rcvd=1.
  - Rising valid, buffer_in_use: frame skipped, storing=0.
  - Valid && storing: write addr rcvd and increment rcvd, only while rcvd < FRAME_SIZE.
  - Falling valid && storing: storing=0, fully_rcvd=1.
  - While fully_rcvd=1, dequeued entries are discarded.
- mac_new_frame_available = buffer_in_use && rcvd>=1 && req==0.
- mac_start_read: accepted when buffer_in_use, req==0, rcvd>=1, !stop_rx and !conflict. Effect: read addr req, then req++.
- mac_rd_avail: asserted one cycle after a RAM read is issued, when all of these hold:
  - buffer_in_use, !stop_rx, !conflict;
  - req>=1 and sent<req;
  - (req<rcvd) || (req==rcvd && fully_rcvd).
- mac_rd_en: sent++. If req<rcvd, also read addr req and req++, so the next byte is valid next cycle (back-to-back rate 1 byte/cycle).
- mac_last_data_rcvd = fully_rcvd && sent==rcvd && buffer_in_use.
- mac_finished_read: honoured when fully_rcvd && !stop_rx && buffer_in_use.
  - Clears buffer_in_use, rcvd, req, sent and fully_rcvd.
  - Asserts conflict for the next cycle, blocking start_read and rd_avail.
- mac_stop_rx: sets stop_rx if buffer_in_use. When stop_rx && fully_rcvd, clear everything, including stop_rx.
- Simultaneous events: stop_rx clear has priority over finished_read. Reset mid-frame discards everything.
- Frame lacking SFD: never stored.

Optional Feature:
ETH_RX_DEBUG_EN: when defined, $display with $time is emitted on:
- frame start (addr, data);
- each stored byte;
- frame skipped;
- frame fully received;
- stop-clear.
Without it, no simulation output and identical RTL.

Decomposition:
Package eth_rx_pkg holds:
- FRAME_SIZE;
- phy_rx_state_t enum {IDLE, PAYLOAD};
- valid_nibble_t {valid, nibble[3:0]};
- valid_byte_t {valid, byte[7:0]}.

One sub-module: eth_rx_frame_ram.
- Simple dual-port RAM, FRAME_SIZE x 8.
- Port A write-only; port B synchronous read with 1-cycle latency.

FIFO and sampler are inline.

Test Plan:
- Reset asserted mid-activity -> all outputs 0; nothing in the RAM is readable.
- Nibbles 5×14, D, then 2,1,4,3,B,A, then dv=0 -> new_frame_available=1. start_read then 3 rd_en yield 0x12, 0x34, 0xAB. bytes_sent=3, last_data_rcvd=1.
- Second frame sent while the first is buffered and unread -> dropped; the first frame still reads 0x12, 0x34, 0xAB. After finished_read, a third frame is stored.
- 1600-byte frame -> rcvd saturates at 1520; exactly 1520 bytes are read, then last_data_rcvd=1.
- stop_rx during frame reception -> after dv falls, all counters are 0 and new_frame_available=0. The next frame is accepted.
- finished_read followed next cycle by a new frame's start_read -> start_read is ignored during the conflict cycle and accepted one cycle later.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive frame buffer.
package eth_rx_pkg;

    localparam int FRAME_SIZE = 1520;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } phy_rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } valid_nibble_t;

    // "byte" is a reserved word, so the payload field is called data.
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } valid_byte_t;

endpackage

// File: rtl/eth_rx_frame_ram.sv
// Single-frame buffer: simple dual-port RAM, write-only port A and
// registered (1-cycle latency) read port B.
module eth_rx_frame_ram #(
    parameter int DEPTH = 1520,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Output register resets so the MAC side sees 0 until the first read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_mii_rx_frame_buffer.sv
// MII receive front end: SFD detect, nibble pairing, byte FIFO, single-frame RAM and
// MAC read-out. Define ETH_RX_DEBUG_EN for $time-stamped event tracing.
module eth_mii_rx_frame_buffer #(
    parameter int FRAME_SIZE = eth_rx_pkg::FRAME_SIZE,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              eth_mii_rx_clk,
    input  logic              eth_mii_rst,
    input  logic              mii_rx_dv,
    input  logic [3:0]        mii_rxd,
    output logic              mac_new_frame_available,
    input  logic              mac_start_read,
    output logic              mac_rd_avail,
    input  logic              mac_rd_en,
    output logic [7:0]        mac_rd_data,
    output logic              mac_last_data_rcvd,
    input  logic              mac_finished_read,
    input  logic              mac_stop_rx,
    output logic [ADDR_W-1:0] mac_bytes_sent
);
    import eth_rx_pkg::*;

    localparam int RAM_AW = $clog2(FRAME_SIZE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] FRAME_MAX = ADDR_W'(FRAME_SIZE);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    valid_nibble_t samp_q, samp_d;
    logic [3:0]    prev_nib_q, prev_nib_d;
    phy_rx_state_t state_q, state_d;
    logic          is_msb_q, is_msb_d;

    valid_byte_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, push_ok, pop;
    valid_byte_t      push_entry, head;

    logic prev_valid_q, prev_valid_d, storing_q, storing_d;
    logic buffer_in_use_q, buffer_in_use_d, fully_rcvd_q, fully_rcvd_d;
    logic stop_rx_q, stop_rx_d, conflict_q, conflict_d;
    logic [ADDR_W-1:0] rcvd_q, rcvd_d, req_q, req_d, sent_q, sent_d;

    logic              ram_we, ram_re, start_ok, rd_ok;
    logic [RAM_AW-1:0] ram_waddr, ram_raddr;
    logic [7:0]        ram_wdata;

    // Sampler and PHY FSM
    always_comb begin
        samp_d     = '{valid: mii_rx_dv, nibble: mii_rxd};
        prev_nib_d = samp_q.nibble;
        state_d    = state_q;
        is_msb_d   = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            IDLE: begin
                push = 1'b1;
                if (samp_q.valid && samp_q.nibble == 4'hD && prev_nib_q == 4'h5)
                    state_d = PAYLOAD;
            end
            PAYLOAD: begin
                is_msb_d = ~is_msb_q;
                if (is_msb_q && samp_q.valid) begin
                    push       = 1'b1;
                    push_entry = '{valid: 1'b1, data: {samp_q.nibble, prev_nib_q}};
                end
                if (!samp_q.valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte FIFO; the store stage drains one entry every cycle it is non-empty
    always_comb begin
        head     = fifo_q[rd_ptr_q];
        pop      = (count_q != '0);
        push_ok  = push && ((count_q != CNT_FULL) || pop);
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    assign mac_new_frame_available = buffer_in_use_q && (rcvd_q != '0) && (req_q == '0);
    assign mac_last_data_rcvd      = fully_rcvd_q && (sent_q == rcvd_q) && buffer_in_use_q;
    assign mac_bytes_sent          = sent_q;
    // While still receiving, the newest byte is held back until another arrives.
    assign mac_rd_avail = buffer_in_use_q && !stop_rx_q && !conflict_q && (req_q != '0) &&
                          (sent_q < req_q) &&
                          ((req_q < rcvd_q) || ((req_q == rcvd_q) && fully_rcvd_q));

    // Store stage and MAC read side
    always_comb begin
        prev_valid_d    = prev_valid_q;
        storing_d       = storing_q;
        buffer_in_use_d = buffer_in_use_q;
        fully_rcvd_d    = fully_rcvd_q;
        stop_rx_d       = stop_rx_q;
        conflict_d      = 1'b0;
        rcvd_d          = rcvd_q;
        req_d           = req_q;
        sent_d          = sent_q;
        ram_we          = 1'b0;
        ram_waddr       = '0;
        ram_wdata       = head.data;
        ram_re          = 1'b0;
        ram_raddr       = '0;

        if (pop) begin
            prev_valid_d = head.valid;
            if (!fully_rcvd_q) begin
                if (head.valid && !prev_valid_q) begin
                    if (!buffer_in_use_q) begin
                        buffer_in_use_d = 1'b1;
                        storing_d       = 1'b1;
                        ram_we          = 1'b1;
                        rcvd_d          = ADDR_W'(1);
                    end else begin
                        storing_d = 1'b0;
                    end
                end else if (head.valid && storing_q) begin
                    if (rcvd_q < FRAME_MAX) begin
                        ram_we    = 1'b1;
                        ram_waddr = rcvd_q[RAM_AW-1:0];
                        rcvd_d    = rcvd_q + 1'b1;
                    end
                end else if (!head.valid && prev_valid_q && storing_q) begin
                    storing_d    = 1'b0;
                    fully_rcvd_d = 1'b1;
                end
            end
        end

        start_ok = mac_start_read && buffer_in_use_q && (req_q == '0) && (rcvd_q != '0) &&
                   !stop_rx_q && !conflict_q;
        rd_ok    = mac_rd_en && mac_rd_avail;
        if (start_ok) begin
            ram_re    = 1'b1;
            ram_raddr = req_q[RAM_AW-1:0];
            req_d     = req_q + 1'b1;
        end
        if (rd_ok) begin
            sent_d = sent_q + 1'b1;
            if (req_q < rcvd_q) begin
                ram_re    = 1'b1;
                ram_raddr = req_q[RAM_AW-1:0];
                req_d     = req_q + 1'b1;
            end
        end

        if (mac_stop_rx && buffer_in_use_q) stop_rx_d = 1'b1;
        if (stop_rx_q && fully_rcvd_q) begin
            buffer_in_use_d = 1'b0;
            storing_d       = 1'b0;
            fully_rcvd_d    = 1'b0;
            stop_rx_d       = 1'b0;
            rcvd_d          = '0;
            req_d           = '0;
            sent_d          = '0;
        end else if (mac_finished_read && fully_rcvd_q && !stop_rx_q && buffer_in_use_q) begin
            buffer_in_use_d = 1'b0;
            fully_rcvd_d    = 1'b0;
            rcvd_d          = '0;
            req_d           = '0;
            sent_d          = '0;
            conflict_d      = 1'b1;
        end
    end

    always_ff @(posedge eth_mii_rx_clk or posedge eth_mii_rst) begin
        if (eth_mii_rst) begin
            samp_q          <= '0;
            prev_nib_q      <= '0;
            state_q         <= IDLE;
            is_msb_q        <= 1'b0;
            fifo_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            prev_valid_q    <= 1'b0;
            storing_q       <= 1'b0;
            buffer_in_use_q <= 1'b0;
            fully_rcvd_q    <= 1'b0;
            stop_rx_q       <= 1'b0;
            conflict_q      <= 1'b0;
            rcvd_q          <= '0;
            req_q           <= '0;
            sent_q          <= '0;
        end else begin
            samp_q          <= samp_d;
            prev_nib_q      <= prev_nib_d;
            state_q         <= state_d;
            is_msb_q        <= is_msb_d;
            fifo_q          <= fifo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            prev_valid_q    <= prev_valid_d;
            storing_q       <= storing_d;
            buffer_in_use_q <= buffer_in_use_d;
            fully_rcvd_q    <= fully_rcvd_d;
            stop_rx_q       <= stop_rx_d;
            conflict_q      <= conflict_d;
            rcvd_q          <= rcvd_d;
            req_q           <= req_d;
            sent_q          <= sent_d;
        end
    end

    eth_rx_frame_ram #(
        .DEPTH (FRAME_SIZE),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (eth_mii_rx_clk),
        .rst     (eth_mii_rst),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (mac_rd_data)
    );

`ifdef ETH_RX_DEBUG_EN
    always @(posedge eth_mii_rx_clk) begin
        if (!eth_mii_rst) begin
            if (ram_we && !storing_q)
                $display("%0t eth_rx: frame start addr=%0d data=%02h", $time, ram_waddr, ram_wdata);
            if (ram_we && storing_q)
                $display("%0t eth_rx: stored addr=%0d data=%02h", $time, ram_waddr, ram_wdata);
            if (pop && !fully_rcvd_q && head.valid && !prev_valid_q && buffer_in_use_q)
                $display("%0t eth_rx: frame skipped, buffer in use", $time);
            if (fully_rcvd_d && !fully_rcvd_q)
                $display("%0t eth_rx: frame fully received, %0d bytes", $time, rcvd_q);
            if (stop_rx_q && fully_rcvd_q)
                $display("%0t eth_rx: stop-clear, frame discarded", $time);
        end
    end
`else
    // Tracing compiled out; the datapath is the same either way.
`endif

endmodule

// File: tb/tb_eth_mii_rx_frame_buffer.sv
// Directed + randomized bench for eth_mii_rx_frame_buffer against a frame-level buffer model.
module tb_eth_mii_rx_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [3:0]  rxd = 4'h0;
    logic        start_rd = 1'b0, rd_en = 1'b0, fin = 1'b0, stop = 1'b0;
    logic        nfa, rd_avail, last;
    logic [7:0]  rd_data;
    logic [15:0] sent;

    always #5 clk = ~clk;

    eth_mii_rx_frame_buffer dut (
        .eth_mii_rx_clk          (clk),
        .eth_mii_rst             (rst),
        .mii_rx_dv               (dv),
        .mii_rxd                 (rxd),
        .mac_new_frame_available (nfa),
        .mac_start_read          (start_rd),
        .mac_rd_avail            (rd_avail),
        .mac_rd_en               (rd_en),
        .mac_rd_data             (rd_data),
        .mac_last_data_rcvd      (last),
        .mac_finished_read       (fin),
        .mac_stop_rx             (stop),
        .mac_bytes_sent          (sent)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] tx_q[$];
    logic [7:0] model_q[$];
    bit         model_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nib(input logic v, input logic [3:0] d);
        dv  = v;
        rxd = d;
        step();
    endtask

    task automatic make_frame(input int len);
        tx_q = {};
        for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic fixed_frame();
        tx_q = {8'h12, 8'h34, 8'hAB};
    endtask

    // Frame enters the buffer only if it has an SFD, the buffer is free and it is not aborted.
    task automatic send_frame(input bit sfd, input int stop_at);
        bit take;
        take = sfd && !model_busy && (stop_at < 0);
        for (int i = 0; i < 14; i++) nib(1'b1, 4'h5);
        if (sfd) nib(1'b1, 4'hD);
        foreach (tx_q[i]) begin
            if (i == stop_at) stop = 1'b1;
            nib(1'b1, tx_q[i][3:0]);
            stop = 1'b0;
            nib(1'b1, tx_q[i][7:4]);
        end
        for (int i = 0; i < 8; i++) nib(1'b0, 4'h0);
        if (take) begin
            model_q = {};
            foreach (tx_q[i]) if (i < 1520) model_q.push_back(tx_q[i]);
            model_busy = 1'b1;
        end
    endtask

    task automatic read_frame(input bit finish);
        int n;
        int w;
        n = model_q.size();
        chk("new_frame_available", nfa, 1);
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!rd_avail && w < 20) begin
                step();
                w++;
            end
            if (!rd_avail) begin
                chk("rd_avail_wait", rd_avail, 1);
                break;
            end
            chk("rd_data", rd_data, model_q[i]);
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        chk("bytes_sent", sent, n);
        chk("last_data_rcvd", last, 1);
        chk("rd_avail_drained", rd_avail, 0);
        if (finish) begin
            fin = 1'b1;
            step();
            fin = 1'b0;
            chk("nfa_after_finish", nfa, 0);
            chk("sent_after_finish", sent, 0);
            chk("last_after_finish", last, 0);
            model_busy = 1'b0;
            model_q    = {};
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_nfa"}, nfa, 0);
        chk({tag, "_rd_avail"}, rd_avail, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_sent"}, sent, 0);
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();
        chk_idle_outputs("post_reset");

        // Directed frame 0x12 0x34 0xAB
        fixed_frame();
        send_frame(1'b1, -1);
        read_frame(1'b1);

        // Second frame while first is buffered is dropped; third is stored after release
        fixed_frame();
        send_frame(1'b1, -1);
        make_frame(10);
        send_frame(1'b1, -1);
        read_frame(1'b1);
        make_frame(25);
        send_frame(1'b1, -1);
        read_frame(1'b1);

        // Frame without SFD is never stored
        fixed_frame();
        send_frame(1'b0, -1);
        chk("no_sfd_nfa", nfa, 0);

        // Oversize frame saturates at 1520 bytes
        make_frame(1600);
        send_frame(1'b1, -1);
        chk("oversize_len", model_q.size(), 1520);
        read_frame(1'b1);

        // Abort during reception discards the frame; next one is accepted
        make_frame(20);
        send_frame(1'b1, 4);
        chk("stop_nfa", nfa, 0);
        chk("stop_sent", sent, 0);
        chk("stop_last", last, 0);
        chk("stop_rd_avail", rd_avail, 0);
        make_frame(7);
        send_frame(1'b1, -1);
        read_frame(1'b1);

        // start_read in the cycle after finished_read is ignored
        make_frame(5);
        send_frame(1'b1, -1);
        read_frame(1'b0);
        fin = 1'b1;
        step();
        fin = 1'b0;
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        chk("conflict_nfa", nfa, 0);
        chk("conflict_rd_avail", rd_avail, 0);
        chk("conflict_sent", sent, 0);
        model_busy = 1'b0;
        model_q    = {};
        make_frame(6);
        send_frame(1'b1, -1);
        read_frame(1'b1);

        // Reset in the middle of reading and receiving
        fixed_frame();
        send_frame(1'b1, -1);
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        chk("mid_first_byte", rd_data, 8'h12);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("mid_sent", sent, 1);
        for (int i = 0; i < 14; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        nib(1'b1, 4'h7);
        nib(1'b1, 4'h9);
        rst = 1'b1;
        step();
        chk_idle_outputs("mid_reset");
        rst = 1'b0;
        dv  = 1'b0;
        step();
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        chk_idle_outputs("after_mid_reset");
        model_busy = 1'b0;
        model_q    = {};

        // Randomized frames, sometimes followed by a frame that must be dropped
        for (int k = 0; k < 6; k++) begin
            make_frame(int'($urandom_range(1, 40)));
            send_frame(1'b1, -1);
            if ($urandom_range(0, 1) == 1) begin
                make_frame(int'($urandom_range(1, 12)));
                send_frame(1'b1, -1);
            end
            read_frame(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
